rank_order_spike_gen: RTL and testbench
=======================================

Name: rank_order_spike_gen

Overview:
Downstream consumer of the pixel-intensity sorter. On the sorter's done pulse it captures the sorted index list and replays it as a stream of rank-ordered spike events (pixel address + rank) into the SNN core's input port, under a valid/ready handshake. An optional programmable gap spaces consecutive spikes.

Parameters:
IMAGE_SIZE, 5, number of pixels and sorted indexes per frame
IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), index counter base width; all index and rank signals are IMAGE_SIZE_BITS+1 bits wide
NUM_SPIKES, IMAGE_SIZE, spikes emitted per frame; legal range 1..IMAGE_SIZE; only ranks 0..NUM_SPIKES-1 are emitted
SPIKE_GAP, 0, idle cycles inserted after each accepted spike except the last
TIME_BITS, 16, timestamp width; used only with SPIKE_TIMESTAMP_EN

Ports:
CLK  in  1  clock; the block has one clock domain
RST  in  1  synchronous, active-high reset
sorted_indexes  in  [IMAGE_SIZE_BITS:0] x [0:IMAGE_SIZE-1]  sorter output; entry 0 is the brightest pixel
sort_done  in  1  one-cycle pulse; sorted_indexes is valid in that cycle
aer_addr  out  IMAGE_SIZE_BITS+1  pixel index of the current spike
aer_rank  out  IMAGE_SIZE_BITS+1  rank (0 = first) of the current spike
aer_valid  out  1  spike event valid
aer_ready  in  1  SNN core accepts the event
busy  out  1  high from capture until the frame_done cycle, inclusive
frame_done  out  1  one-cycle pulse after the last spike is accepted
overrun  out  1  one-cycle pulse when a sort_done arrives while not in IDLE
aer_time  out  TIME_BITS  present only with SPIKE_TIMESTAMP_EN

Behaviour:
- Reset is synchronous: RST at a clock edge forces state to IDLE and sets every output and register to 0 (aer_addr, aer_rank, aer_valid, busy, frame_done, overrun, aer_time, rank counter, gap counter, buffer). This applies mid-frame as well; the frame in progress is dropped and no frame_done is issued.
- All outputs are driven from registers. There are no combinational paths from inputs to outputs, including from aer_ready to aer_valid.
- States:
  - IDLE: busy=0, aer_valid=0. If sort_done=1, capture all IMAGE_SIZE entries into an internal buffer, set rank=0 and go to EMIT.
  - EMIT: aer_valid=1, aer_addr=buf[rank], aer_rank=rank. Outputs hold stable until aer_valid && aer_ready.
    - On acceptance with rank==NUM_SPIKES-1, go to FINISH.
    - On acceptance otherwise, rank++. With SPIKE_GAP==0, stay in EMIT so the next spike is presented in the next cycle. Otherwise go to GAP.
  - GAP: aer_valid=0 for exactly SPIKE_GAP cycles, then return to EMIT.
  - FINISH: frame_done=1 and busy=1 for one cycle, then go to IDLE.
- Latency: with aer_ready held at 1, the first aer_valid appears the cycle after sort_done. The frame takes NUM_SPIKES + (NUM_SPIKES-1)*SPIKE_GAP cycles of EMIT/GAP, then 1 FINISH cycle.
- sort_done is only accepted in IDLE. In any other state, including the FINISH cycle, it is ignored: the buffer and the current frame are unaffected, and overrun pulses in the following cycle. Upstream must not issue a new frame while busy=1.
- Buffer contents are passed through unchecked. Index values >= IMAGE_SIZE go out unchanged.
- The rank counter never exceeds NUM_SPIKES-1, so there is no wrap-around.

Optional Feature:
SPIKE_TIMESTAMP_EN
- Defined:
  - A TIME_BITS counter clears to 0 on capture and increments every cycle while in EMIT or GAP.
  - aer_time carries the counter value for the presented event and is held stable together with aer_addr while stalled.
  - The counter wraps modulo 2^TIME_BITS.
  - aer_time is 0 in IDLE and on reset.
- Undefined: the aer_time port and counter do not exist; all other behaviour is identical.

Test Plan:
1. Defaults, sorted_indexes={3,0,4,1,2}, sort_done at cycle 0, aer_ready=1 -> (addr,rank)=(3,0),(0,1),(4,2),(1,3),(2,4) on cycles 1-5; frame_done at cycle 6; busy high for cycles 1-6.
2. Same frame, aer_ready low for cycles 1-3 -> aer_valid high with addr=3, rank=0 held through cycles 1-3; accepted at cycle 4; remaining spikes on cycles 5-8; frame_done at cycle 9.
3. SPIKE_GAP=2, NUM_SPIKES=3, aer_ready=1 -> spikes on cycles 1, 4, 7 (addr 3, 0, 4); aer_valid low on cycles 2-3 and 5-6; frame_done at cycle 8.
4. Second sort_done with sorted_indexes={1,1,1,1,1} at cycle 3 of frame 1 -> overrun=1 at cycle 4; frame 1 outputs unchanged (addr 1 at cycle 4, 2 at cycle 5).
5. RST asserted at cycle 3 mid-frame -> at cycle 4 all outputs are 0 and there is no frame_done; a new sort_done at cycle 6 gives rank 0 at cycle 7.
6. SPIKE_TIMESTAMP_EN, SPIKE_GAP=1 -> aer_time=0, 2, 4, 6, 8 accompanying ranks 0-4.

Source files
------------

// File: rtl/rank_order_spike_gen.sv
// Replays a captured sorted-index frame as rank-ordered AER spike events under valid/ready.
// Optional macro SPIKE_TIMESTAMP_EN adds the aer_time port and its cycle counter.
module rank_order_spike_gen #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int NUM_SPIKES      = IMAGE_SIZE,
  parameter int SPIKE_GAP       = 0,
  parameter int TIME_BITS       = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [IMAGE_SIZE_BITS:0] sorted_indexes [0:IMAGE_SIZE-1],
  input  logic                     sort_done,
  output logic [IMAGE_SIZE_BITS:0] aer_addr,
  output logic [IMAGE_SIZE_BITS:0] aer_rank,
  output logic                     aer_valid,
  input  logic                     aer_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
`ifdef SPIKE_TIMESTAMP_EN
  ,
  output logic [TIME_BITS-1:0]     aer_time
`endif
);

  localparam int IW       = IMAGE_SIZE_BITS + 1;
  localparam int GAP_BITS = (SPIKE_GAP > 1) ? $clog2(SPIKE_GAP) : 1;
  localparam logic [IW-1:0]       LAST_RANK = IW'(NUM_SPIKES - 1);
  localparam logic [GAP_BITS-1:0] GAP_LOAD  = GAP_BITS'((SPIKE_GAP > 0) ? SPIKE_GAP - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EMIT   = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  if (NUM_SPIKES < 1 || NUM_SPIKES > IMAGE_SIZE || TIME_BITS < 1) begin : g_param_check
    $error("rank_order_spike_gen: illegal NUM_SPIKES or TIME_BITS");
  end

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       rank_q, rank_d;
  logic [GAP_BITS-1:0] gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]       idx_buf_q [0:IMAGE_SIZE-1];
  logic [IW-1:0]       idx_buf_d [0:IMAGE_SIZE-1];
  logic [IW-1:0]       aer_addr_q, aer_addr_d;
  logic [IW-1:0]       aer_rank_q, aer_rank_d;
  logic                aer_valid_q, aer_valid_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic [IW-1:0]       sel_rank;
  logic [IW-1:0]       sel_addr;
`ifdef SPIKE_TIMESTAMP_EN
  logic [TIME_BITS-1:0] time_q, time_d;
  logic [TIME_BITS-1:0] aer_time_q, aer_time_d;
`endif

  // In GAP the rank was already advanced on acceptance; in EMIT the next event is rank+1.
  always_comb begin
    sel_rank = (state_q == ST_GAP) ? rank_q : rank_q + IW'(1);
    sel_addr = '0;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      if (sel_rank == IW'(i)) sel_addr = idx_buf_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    rank_d       = rank_q;
    gap_cnt_d    = gap_cnt_q;
    idx_buf_d    = idx_buf_q;
    aer_addr_d   = aer_addr_q;
    aer_rank_d   = aer_rank_q;
    aer_valid_d  = aer_valid_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overrun_d    = sort_done && (state_q != ST_IDLE);
`ifdef SPIKE_TIMESTAMP_EN
    time_d     = time_q;
    aer_time_d = aer_time_q;
    if (state_q == ST_EMIT || state_q == ST_GAP) time_d = time_q + TIME_BITS'(1);
`endif
    case (state_q)
      ST_IDLE: begin
        if (sort_done) begin
          idx_buf_d   = sorted_indexes;
          rank_d      = '0;
          aer_addr_d  = sorted_indexes[0];
          aer_rank_d  = '0;
          aer_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_EMIT;
`ifdef SPIKE_TIMESTAMP_EN
          time_d     = '0;
          aer_time_d = '0;
`endif
        end
      end
      ST_EMIT: begin
        if (aer_valid_q && aer_ready) begin
          if (rank_q == LAST_RANK) begin
            aer_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_FINISH;
          end else begin
            rank_d = rank_q + IW'(1);
            if (SPIKE_GAP == 0) begin
              aer_addr_d = sel_addr;
              aer_rank_d = sel_rank;
`ifdef SPIKE_TIMESTAMP_EN
              aer_time_d = time_q + TIME_BITS'(1);
`endif
            end else begin
              aer_valid_d = 1'b0;
              gap_cnt_d   = GAP_LOAD;
              state_d     = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          aer_valid_d = 1'b1;
          aer_addr_d  = sel_addr;
          aer_rank_d  = rank_q;
          state_d     = ST_EMIT;
`ifdef SPIKE_TIMESTAMP_EN
          aer_time_d = time_q + TIME_BITS'(1);
`endif
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_BITS'(1);
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`ifdef SPIKE_TIMESTAMP_EN
        time_d     = '0;
        aer_time_d = '0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      rank_q       <= '0;
      gap_cnt_q    <= '0;
      idx_buf_q    <= '{default: '0};
      aer_addr_q   <= '0;
      aer_rank_q   <= '0;
      aer_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SPIKE_TIMESTAMP_EN
      time_q     <= '0;
      aer_time_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rank_q       <= rank_d;
      gap_cnt_q    <= gap_cnt_d;
      idx_buf_q    <= idx_buf_d;
      aer_addr_q   <= aer_addr_d;
      aer_rank_q   <= aer_rank_d;
      aer_valid_q  <= aer_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef SPIKE_TIMESTAMP_EN
      time_q     <= time_d;
      aer_time_q <= aer_time_d;
`endif
    end
  end

  assign aer_addr   = aer_addr_q;
  assign aer_rank   = aer_rank_q;
  assign aer_valid  = aer_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
`ifdef SPIKE_TIMESTAMP_EN
  assign aer_time   = aer_time_q;
`endif

endmodule

// File: tb/tb_rank_order_spike_gen.sv
// Directed bench for rank_order_spike_gen: a default instance and a gapped, shortened instance,
// with spike events checked against a queue of expected (addr, rank, time) entries.
module tb_rank_order_spike_gen;

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  rank;
    logic [15:0] tstamp;
  } spike_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] idx0 [0:4];
  logic [3:0] idx1 [0:4];
  logic       sd0, sd1, ready0, ready1;
  logic [3:0] addr0, rank0, addr1, rank1;
  logic       valid0, busy0, fdone0, ovr0;
  logic       valid1, busy1, fdone1, ovr1;
`ifdef SPIKE_TIMESTAMP_EN
  logic [15:0] time0, time1;
`endif

  spike_t exp0_q[$];
  spike_t exp1_q[$];
  int     errors = 0;
  int     checks = 0;

  always #5 CLK = ~CLK;

  rank_order_spike_gen dut0 (
    .CLK(CLK), .RST(RST), .sorted_indexes(idx0), .sort_done(sd0),
    .aer_addr(addr0), .aer_rank(rank0), .aer_valid(valid0), .aer_ready(ready0),
    .busy(busy0), .frame_done(fdone0), .overrun(ovr0)
`ifdef SPIKE_TIMESTAMP_EN
    , .aer_time(time0)
`endif
  );

  rank_order_spike_gen #(.NUM_SPIKES(3), .SPIKE_GAP(2)) dut1 (
    .CLK(CLK), .RST(RST), .sorted_indexes(idx1), .sort_done(sd1),
    .aer_addr(addr1), .aer_rank(rank1), .aer_valid(valid1), .aer_ready(ready1),
    .busy(busy1), .frame_done(fdone1), .overrun(ovr1)
`ifdef SPIKE_TIMESTAMP_EN
    , .aer_time(time1)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic push0(input int n);
    for (int r = 0; r < n; r++) exp0_q.push_back('{addr: idx0[r], rank: 4'(r), tstamp: 16'd0});
  endtask

  // Gap of 2 means each event's timestamp is three cycles after the previous one.
  task automatic push1(input int n);
    for (int r = 0; r < n; r++) exp1_q.push_back('{addr: idx1[r], rank: 4'(r), tstamp: 16'(3 * r)});
  endtask

  // Called mid-cycle after inputs for this cycle are set; an accepted event pops the queue.
  task automatic score();
    spike_t s;
    if (!RST && valid0 && ready0) begin
      check_output("dut0_expected_spike", 32'(exp0_q.size() != 0), 32'd1);
      if (exp0_q.size() != 0) begin
        s = exp0_q.pop_front();
        check_output("dut0_addr", 32'(addr0), 32'(s.addr));
        check_output("dut0_rank", 32'(rank0), 32'(s.rank));
      end
    end
    if (!RST && valid1 && ready1) begin
      check_output("dut1_expected_spike", 32'(exp1_q.size() != 0), 32'd1);
      if (exp1_q.size() != 0) begin
        s = exp1_q.pop_front();
        check_output("dut1_addr", 32'(addr1), 32'(s.addr));
        check_output("dut1_rank", 32'(rank1), 32'(s.rank));
`ifdef SPIKE_TIMESTAMP_EN
        check_output("dut1_time", 32'(time1), 32'(s.tstamp));
`endif
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_valid0"}, 32'(valid0), 32'd0);
    check_output({tag, "_busy0"}, 32'(busy0), 32'd0);
    check_output({tag, "_fdone0"}, 32'(fdone0), 32'd0);
    check_output({tag, "_ovr0"}, 32'(ovr0), 32'd0);
    check_output({tag, "_addr0"}, 32'(addr0), 32'd0);
    check_output({tag, "_rank0"}, 32'(rank0), 32'd0);
`ifdef SPIKE_TIMESTAMP_EN
    check_output({tag, "_time0"}, 32'(time0), 32'd0);
`endif
  endtask

  initial begin
    bit seen;
    RST = 1'b1; sd0 = 1'b0; sd1 = 1'b0; ready0 = 1'b1; ready1 = 1'b1;
    idx0 = '{default: 4'd0};
    idx1 = '{default: 4'd0};
    @(negedge CLK);
    next_cycle();
    check_reset_state("reset");
    check_output("reset_valid1", 32'(valid1), 32'd0);
    check_output("reset_busy1", 32'(busy1), 32'd0);
    RST = 1'b0;
    next_cycle();

    $display("[TB] frame with aer_ready held high");
    idx0 = '{4'd3, 4'd0, 4'd4, 4'd1, 4'd2};
    sd0 = 1'b1; push0(5); score();
    for (int c = 1; c <= 7; c++) begin
      next_cycle(); sd0 = 1'b0; score();
      check_output($sformatf("t1_busy_c%0d", c), 32'(busy0), 32'(c <= 6));
      check_output($sformatf("t1_fdone_c%0d", c), 32'(fdone0), 32'(c == 6));
      check_output($sformatf("t1_valid_c%0d", c), 32'(valid0), 32'(c <= 5));
    end
    check_output("t1_queue_drained", 32'(exp0_q.size()), 32'd0);

    $display("[TB] frame with first spike stalled");
    sd0 = 1'b1; push0(5); score();
    for (int c = 1; c <= 10; c++) begin
      next_cycle(); sd0 = 1'b0; ready0 = (c >= 4); score();
      if (c <= 3) begin
        check_output($sformatf("t2_valid_c%0d", c), 32'(valid0), 32'd1);
        check_output($sformatf("t2_addr_c%0d", c), 32'(addr0), 32'd3);
        check_output($sformatf("t2_rank_c%0d", c), 32'(rank0), 32'd0);
      end
      check_output($sformatf("t2_fdone_c%0d", c), 32'(fdone0), 32'(c == 9));
    end
    check_output("t2_queue_drained", 32'(exp0_q.size()), 32'd0);
    ready0 = 1'b1;

    $display("[TB] gapped frame of three spikes");
    idx1 = '{4'd3, 4'd0, 4'd4, 4'd1, 4'd2};
    sd1 = 1'b1; push1(3); score();
    for (int c = 1; c <= 9; c++) begin
      next_cycle(); sd1 = 1'b0; score();
      check_output($sformatf("t3_valid_c%0d", c), 32'(valid1), 32'(c == 1 || c == 4 || c == 7));
      check_output($sformatf("t3_fdone_c%0d", c), 32'(fdone1), 32'(c == 8));
      check_output($sformatf("t3_busy_c%0d", c), 32'(busy1), 32'(c <= 8));
    end
    check_output("t3_queue_drained", 32'(exp1_q.size()), 32'd0);

    $display("[TB] sort_done while busy and during the finish cycle");
    sd0 = 1'b1; push0(5); score();
    for (int c = 1; c <= 9; c++) begin
      next_cycle(); sd0 = 1'b0;
      if (c == 3) begin
        idx0 = '{default: 4'd1};
        sd0 = 1'b1;
      end
      if (c == 6) sd0 = 1'b1;
      score();
      check_output($sformatf("t4_ovr_c%0d", c), 32'(ovr0), 32'(c == 4 || c == 7));
      check_output($sformatf("t4_fdone_c%0d", c), 32'(fdone0), 32'(c == 6));
      if (c >= 7) check_output($sformatf("t4_valid_c%0d", c), 32'(valid0), 32'd0);
    end
    check_output("t4_queue_drained", 32'(exp0_q.size()), 32'd0);

    $display("[TB] reset in the middle of a frame");
    idx0 = '{4'd3, 4'd0, 4'd4, 4'd1, 4'd2};
    sd0 = 1'b1; push0(5); score();
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); sd0 = 1'b0;
      if (c == 3) RST = 1'b1;
      score();
    end
    next_cycle(); RST = 1'b0;
    exp0_q.delete();
    check_reset_state("t5_after_reset");
    for (int c = 5; c <= 6; c++) begin
      next_cycle();
      check_output($sformatf("t5_fdone_c%0d", c), 32'(fdone0), 32'd0);
      check_output($sformatf("t5_valid_c%0d", c), 32'(valid0), 32'd0);
    end
    sd0 = 1'b1; push0(5); score();
    next_cycle(); sd0 = 1'b0;
    check_output("t5_restart_valid", 32'(valid0), 32'd1);
    check_output("t5_restart_rank", 32'(rank0), 32'd0);
    score();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      next_cycle(); score();
      if (fdone0) seen = 1'b1;
    end
    check_output("t5_frame_done_seen", 32'(seen), 32'd1);
    check_output("t5_queue_drained", 32'(exp0_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
